// File: rtl/music_seq.sv
// Song sequencer: walks a synchronous note ROM one note per beat and drives a square-wave tone.
// Optional MUSIC_ARTIC_EN: silences speak for the last BEAT_CYC/8 cycles of each beat.
module music_seq #(
  parameter int CLK_HZ   = 1_000_000,
  parameter int BEAT_HZ  = 4,
  parameter int ADDR_W   = 8,
  parameter int SONG_LEN = 139,
  parameter int DIV_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  input  logic [3:0]        note_code,
  output logic [ADDR_W-1:0] note_addr,
  output logic              speak,
  output logic              high,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done
);

  localparam int BEAT_CYC = CLK_HZ / BEAT_HZ;
  localparam int BEAT_W   = $clog2(BEAT_CYC);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
`ifdef MUSIC_ARTIC_EN
  // Beat value one before the silent tail starts (speak is registered one edge ahead).
  localparam logic [BEAT_W-1:0] GAP_PREV = BEAT_W'(BEAT_CYC - BEAT_CYC / 8 - 1);
`endif

  typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, PLAY, PAUSED} state_t;

  function automatic int freq_of(input int code);
    case (code)
      1:       return 262;
      2:       return 294;
      3:       return 330;
      4:       return 349;
      5:       return 392;
      6:       return 440;
      7:       return 494;
      8:       return 523;
      9:       return 587;
      10:      return 659;
      11:      return 698;
      12:      return 784;
      13:      return 880;
      14:      return 988;
      15:      return 1046;
      default: return 0;
    endcase
  endfunction

  logic [DIV_W-1:0] hp_tab [16];
  logic [3:0]       led_tab [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_note
    localparam int F = freq_of(gi);
    assign hp_tab[gi]  = (F == 0) ? '0 : DIV_W'(CLK_HZ / (2 * ((F == 0) ? 1 : F)));
    assign led_tab[gi] = (gi == 0)  ? 4'd0 :
                         (gi <= 7)  ? 4'(gi) :
                         (gi <= 14) ? 4'(gi - 7) : 4'd1;
  end

  state_t            state_reg;
  logic [BEAT_W-1:0] beat_cnt_reg;
  logic [DIV_W-1:0]  tone_cnt_reg;
  logic [DIV_W-1:0]  hp_reg;
  logic              code_nz_reg;
  logic              tone_lvl_reg;
  logic [ADDR_W-1:0] note_addr_reg;
  logic              speak_reg;
  logic              high_reg;
  logic [3:0]        led_reg;
  logic              busy_reg;
  logic              done_reg;

  logic             run;
  logic             beat_end;
  logic             tone_hit;
  logic             speak_next;
  logic [DIV_W-1:0] hp_last;

  // PLAY and PAUSED both advance on an edge where pause is low, so the time lost
  // to a pause equals exactly the number of edges pause was sampled high.
  assign run      = ((state_reg == PLAY) || (state_reg == PAUSED)) && !pause;
  assign beat_end = (beat_cnt_reg == BEAT_LAST);
  assign hp_last  = hp_reg - DIV_W'(1);
  assign tone_hit = (tone_cnt_reg == hp_last);

`ifdef MUSIC_ARTIC_EN
  assign speak_next = (tone_lvl_reg ^ tone_hit) & ~(beat_cnt_reg >= GAP_PREV);
`else
  assign speak_next = tone_lvl_reg ^ tone_hit;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      beat_cnt_reg  <= '0;
      tone_cnt_reg  <= '0;
      hp_reg        <= '0;
      code_nz_reg   <= 1'b0;
      tone_lvl_reg  <= 1'b0;
      note_addr_reg <= '0;
      speak_reg     <= 1'b0;
      high_reg      <= 1'b0;
      led_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (stop) begin
        state_reg     <= IDLE;
        beat_cnt_reg  <= '0;
        tone_cnt_reg  <= '0;
        tone_lvl_reg  <= 1'b0;
        note_addr_reg <= '0;
        speak_reg     <= 1'b0;
        high_reg      <= 1'b0;
        led_reg       <= '0;
        busy_reg      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (play) begin
              state_reg     <= FETCH_A;
              note_addr_reg <= '0;
              beat_cnt_reg  <= '0;
              busy_reg      <= 1'b1;
            end
          end
          FETCH_A: begin
            state_reg    <= FETCH_B;
            beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
            tone_cnt_reg <= '0;
            tone_lvl_reg <= 1'b0;
            speak_reg    <= 1'b0;
          end
          FETCH_B: begin
            // ROM data for note_addr is valid in this cycle.
            state_reg    <= PLAY;
            beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
            tone_cnt_reg <= '0;
            tone_lvl_reg <= 1'b0;
            speak_reg    <= 1'b0;
            code_nz_reg  <= (note_code != 4'd0);
            hp_reg       <= hp_tab[note_code];
            high_reg     <= note_code[3];
            led_reg      <= led_tab[note_code];
          end
          PLAY, PAUSED: begin
            if (!run) begin
              state_reg    <= PAUSED;
              tone_lvl_reg <= 1'b0;
              speak_reg    <= 1'b0;
            end else if (beat_end) begin
              beat_cnt_reg <= '0;
              tone_cnt_reg <= '0;
              tone_lvl_reg <= 1'b0;
              speak_reg    <= 1'b0;
              if (note_addr_reg != ADDR_LAST) begin
                state_reg     <= FETCH_A;
                note_addr_reg <= note_addr_reg + ADDR_W'(1);
              end else if (loop) begin
                state_reg     <= FETCH_A;
                note_addr_reg <= '0;
              end else begin
                state_reg     <= IDLE;
                note_addr_reg <= '0;
                high_reg      <= 1'b0;
                led_reg       <= '0;
                busy_reg      <= 1'b0;
                done_reg      <= 1'b1;
              end
            end else begin
              state_reg    <= PLAY;
              beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
              if (code_nz_reg) begin
                if (tone_hit) begin
                  tone_cnt_reg <= '0;
                  tone_lvl_reg <= ~tone_lvl_reg;
                end else begin
                  tone_cnt_reg <= tone_cnt_reg + DIV_W'(1);
                end
                speak_reg <= speak_next;
              end else begin
                tone_cnt_reg <= '0;
                tone_lvl_reg <= 1'b0;
                speak_reg    <= 1'b0;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign note_addr = note_addr_reg;
  assign speak     = speak_reg;
  assign high      = high_reg;
  assign led       = led_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_music_seq.sv
// Bench for music_seq: 4-note song {15,0,8,15}, 1000-cycle beats, table checks plus
// a scoreboard of note_addr changes and done pulses.
module tb_music_seq;

  localparam int ADDR_W = 8;
`ifdef MUSIC_ARTIC_EN
  localparam bit ARTIC = 1'b1;
`else
  localparam bit ARTIC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              play = 1'b0;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic              loop = 1'b0;
  logic [3:0]        note_code;
  logic [ADDR_W-1:0] note_addr;
  logic              speak;
  logic              high;
  logic [3:0]        led;
  logic              busy;
  logic              done;

  music_seq #(
    .CLK_HZ(1_000_000), .BEAT_HZ(1000), .ADDR_W(ADDR_W), .SONG_LEN(4), .DIV_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .play(play), .stop(stop), .pause(pause), .loop(loop),
    .note_code(note_code), .note_addr(note_addr), .speak(speak), .high(high),
    .led(led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] rom [4];
  initial begin
    rom[0] = 4'd15; rom[1] = 4'd0; rom[2] = 4'd8; rom[3] = 4'd15;
  end
  always @(posedge clk) note_code <= (note_addr < 4) ? rom[note_addr[1:0]] : 4'd0;

  int total = 0;
  int bad = 0;

  typedef struct { int cyc; int addr; int done; } ev_t;
  ev_t sb_q[$];

  typedef struct { int t; int addr; int busy; int led; int high; int lvl; int done; bit poke; } vec_t;
  vec_t vecs[$];

  logic              mon_en = 1'b0;
  logic [ADDR_W-1:0] prev_addr;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int exp_speak(input int lvl, input int beat);
    return (lvl != 0 && !(ARTIC && beat >= 875)) ? 1 : 0;
  endfunction

  task automatic check_out(input string tag, input int a, input int b, input int l,
                           input int h, input int s, input int d);
    $display("%s cyc=%0d addr=%0d busy=%0d led=%0d high=%0d speak=%0d done=%0d",
             tag, cyc, note_addr, busy, led, high, speak, done);
    chk({tag, ".addr"}, int'(note_addr), a);
    chk({tag, ".busy"}, int'(busy), b);
    chk({tag, ".led"}, int'(led), l);
    chk({tag, ".high"}, int'(high), h);
    chk({tag, ".speak"}, int'(speak), s);
    chk({tag, ".done"}, int'(done), d);
  endtask

  task automatic add_vec(input int t, input int a, input int b, input int l,
                         input int h, input int lv, input int d, input bit pk);
    vec_t v;
    v.t = t; v.addr = a; v.busy = b; v.led = l; v.high = h; v.lvl = lv; v.done = d; v.poke = pk;
    vecs.push_back(v);
  endtask

  task automatic push_ev(input int c, input int a, input int d);
    ev_t e;
    e.cyc = c; e.addr = a; e.done = d;
    sb_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start(output int p);
    @(negedge clk);
    play = 1'b1;
    p = cyc + 1;
    @(negedge clk);
    play = 1'b0;
  endtask

  // Scoreboard side: every note_addr change or done pulse must match the next expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (note_addr !== prev_addr || done === 1'b1) begin
          $display("event cyc=%0d addr=%0d done=%0d", cyc, note_addr, done);
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected cyc=%0d got addr=%0d done=%0d want no event",
                     cyc, note_addr, done);
          end else begin
            ev_t e;
            e = sb_q.pop_front();
            chk("ev.cyc", cyc, e.cyc);
            chk("ev.addr", int'(note_addr), e.addr);
            chk("ev.done", int'(done), e.done);
          end
        end
        prev_addr = note_addr;
      end
    end
  end

  initial begin
    int p;

    // Expected one-shot trace, t = edges after the play edge.
    add_vec(0,    0, 1, 0, 0, 0, 0, 1'b0);
    add_vec(1,    0, 1, 0, 0, 0, 0, 1'b0);
    add_vec(2,    0, 1, 1, 1, 0, 0, 1'b0);
    add_vec(479,  0, 1, 1, 1, 0, 0, 1'b0);
    add_vec(480,  0, 1, 1, 1, 1, 0, 1'b0);
    add_vec(874,  0, 1, 1, 1, 1, 0, 1'b0);
    add_vec(875,  0, 1, 1, 1, 1, 0, 1'b0);
    add_vec(957,  0, 1, 1, 1, 1, 0, 1'b0);
    add_vec(958,  0, 1, 1, 1, 0, 0, 1'b0);
    add_vec(1000, 1, 1, 1, 1, 0, 0, 1'b0);
    add_vec(1001, 1, 1, 1, 1, 0, 0, 1'b0);
    add_vec(1002, 1, 1, 0, 0, 0, 0, 1'b0);
    add_vec(1500, 1, 1, 0, 0, 0, 0, 1'b1);
    add_vec(1600, 1, 1, 0, 0, 0, 0, 1'b0);
    add_vec(2001, 2, 1, 0, 0, 0, 0, 1'b0);
    add_vec(2002, 2, 1, 1, 1, 0, 0, 1'b0);
    add_vec(2957, 2, 1, 1, 1, 0, 0, 1'b0);
    add_vec(2958, 2, 1, 1, 1, 1, 0, 1'b0);
    add_vec(3002, 3, 1, 1, 1, 0, 0, 1'b0);
    add_vec(3480, 3, 1, 1, 1, 1, 0, 1'b0);
    add_vec(3999, 3, 1, 1, 1, 0, 0, 1'b0);
    add_vec(4000, 0, 0, 0, 0, 0, 1, 1'b0);
    add_vec(4001, 0, 0, 0, 0, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    check_out("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    prev_addr = note_addr;
    mon_en = 1'b1;

    // One-shot run, with an ignored play pulse mid-song.
    start(p);
    push_ev(p + 1000, 1, 0);
    push_ev(p + 2000, 2, 0);
    push_ev(p + 3000, 3, 0);
    push_ev(p + 4000, 0, 1);
    for (int i = 0; i < vecs.size(); i++) begin
      wait_to(p + vecs[i].t);
      check_out($sformatf("vec%0d", i), vecs[i].addr, vecs[i].busy, vecs[i].led, vecs[i].high,
                exp_speak(vecs[i].lvl, vecs[i].t % 1000), vecs[i].done);
      if (vecs[i].poke) begin
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
      end
    end

    // Pause 300 edges in note 0 while the tone is high.
    start(p);
    push_ev(p + 1300, 1, 0);
    push_ev(p + 2300, 2, 0);
    push_ev(p + 3300, 3, 0);
    push_ev(p + 4300, 0, 1);
    wait_to(p + 500);
    check_out("pre_pause", 0, 1, 1, 1, exp_speak(1, 500), 0);
    pause = 1'b1;
    wait_to(p + 600);
    check_out("paused", 0, 1, 1, 1, 0, 0);
    wait_to(p + 800);
    pause = 1'b0;
    wait_to(p + 801);
    check_out("unpause", 0, 1, 1, 1, 0, 0);
    wait_to(p + 1257);
    check_out("resume_lo", 0, 1, 1, 1, 0, 0);
    wait_to(p + 1258);
    check_out("resume_hi", 0, 1, 1, 1, exp_speak(1, 958), 0);
    wait_to(p + 4301);
    check_out("pause_end", 0, 0, 0, 0, 0, 0);

    // Loop run, then stop together with play.
    loop = 1'b1;
    start(p);
    push_ev(p + 1000, 1, 0);
    push_ev(p + 2000, 2, 0);
    push_ev(p + 3000, 3, 0);
    push_ev(p + 4000, 0, 0);
    wait_to(p + 4000);
    check_out("loop_wrap", 0, 1, 1, 1, 0, 0);
    wait_to(p + 4700);
    check_out("loop_tone", 0, 1, 1, 1, exp_speak(1, 700), 0);
    stop = 1'b1;
    play = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    play = 1'b0;
    loop = 1'b0;
    check_out("stop_play", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_out("stop_hold", 0, 0, 0, 0, 0, 0);

    // Synchronous reset in the middle of note 3.
    start(p);
    push_ev(p + 1000, 1, 0);
    push_ev(p + 2000, 2, 0);
    push_ev(p + 3000, 3, 0);
    wait_to(p + 3700);
    check_out("pre_rst", 3, 1, 1, 1, exp_speak(1, 700), 0);
    push_ev(p + 3701, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_out("mid_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_out("post_rst", 0, 0, 0, 0, 0, 0);

    repeat (5) @(negedge clk);
    chk("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/music_seq.md
# music_seq

Parametrised single-clock music sequencer: steps through a song stored in an external synchronous note ROM, one note per beat. Each 4-bit note code is converted to a tone half-period, and a 50%-duty square wave is driven on `speak`. It replaces the divider / address-counter / note-decode / speaker-divider / toggle chain of the player with one block. It adds play/stop/pause control, loop or one-shot mode, a configurable song length and clock-independent tone generation.

## Interface
- `CLK_HZ`, 1_000_000: system clock frequency.
- `BEAT_HZ`, 4: notes per second. `BEAT_CYC = CLK_HZ/BEAT_HZ`, which must be ≥ 16.
- `ADDR_W`, 8: note ROM address width.
- `SONG_LEN`, 139: number of notes, 1..2^ADDR_W.
- `DIV_W`, 16: tone counter width. Must hold the largest half-period `HP`.

- `clk`  in  1: system clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `play`  in  1: one-cycle start pulse.
- `stop`  in  1: one-cycle stop pulse.
- `pause`  in  1: level; freezes playback while high.
- `loop`  in  1: level; sampled at song end. 1 = restart, 0 = one-shot.
- `note_code`  in  4: ROM data. Valid the cycle after `note_addr` is sampled by the ROM.
- `note_addr`  out  ADDR_W: registered ROM address.
- `speak`  out  1: square-wave tone.
- `high`  out  1: current note is mid/high octave (code ≥ 8).
- `led`  out  4: scale degree 1..7 of current note; 0 for rest.
- `busy`  out  1: state ≠ IDLE.
- `done`  out  1: one-cycle pulse at the end of a one-shot song.

## Operation
- Note codes:
  - 0 = rest.
  - 1..7 = low C..B: 262, 294, 330, 349, 392, 440, 494 Hz.
  - 8..14 = mid C..B: 523, 587, 659, 698, 784, 880, 988 Hz.
  - 15 = high C, 1046 Hz.
- Half-period: `HP = floor(CLK_HZ/(2·f))`, computed as localparams at elaboration.
- `led`: code for 1..7; code−7 for 8..14; 1 for 15; 0 for rest.
- States:
  - IDLE: `note_addr`=0, `speak`=0.
  - FETCH_A: ROM samples `note_addr`.
  - FETCH_B: `note_code` latched on exit; tone counter and `speak` cleared.
  - PLAY.
  - PAUSED.
- Transitions:
  - IDLE + `play` → FETCH_A, address 0.
  - FETCH_A → FETCH_B → PLAY.
  - PLAY + `pause` → PAUSED. PAUSED + !`pause` → PLAY.
  - PLAY, beat counter = BEAT_CYC−1, address < SONG_LEN−1 → address+1, FETCH_A.
  - Same, address = SONG_LEN−1, `loop`=1 → address 0, FETCH_A.
  - Same, address = SONG_LEN−1, `loop`=0 → IDLE, `done` pulsed.
  - `stop` in any state → IDLE next cycle. `stop` beats `play` when both are asserted.
  - `play` while busy is ignored.
- Beat counter:
  - Cleared on FETCH_A entry.
  - Counts in FETCH_A, FETCH_B and PLAY. Each note therefore spans exactly BEAT_CYC cycles.
  - Frozen in PAUSED.
- Tone generator, in PLAY with a nonzero code:
  - When tone counter = HP−1: clear the counter and toggle `speak`.
  - Otherwise increment the counter.
- Tone generator, on rest, FETCH_A/B, PAUSED or IDLE:
  - `speak`=0.
  - In PAUSED the counter holds; `speak` resumes from 0 on unpause.
- `high`/`led` update when the code is latched and hold until the next latch. Both are cleared in IDLE.

## Timing
- Reset (`rst_n`=0 at an edge): IDLE; all outputs 0; counters 0.
- `play` at edge n → `busy`=1 and `note_addr`=0 after edge n.
- `note_code` is captured on the edge that leaves FETCH_B, which is edge n+2.
- First `speak` rise occurs HP cycles after PLAY entry.
- `done` is high for exactly one cycle, the cycle `busy` falls.
- `note_addr` changes only on FETCH_A entry. It wraps to 0 only via loop.

## Configuration
- `MUSIC_ARTIC_EN` defined: `speak` is forced 0 during the last BEAT_CYC/8 cycles of every beat. Repeated identical notes are then audibly separated. The tone counter keeps running during the gap.
- `MUSIC_ARTIC_EN` undefined: `speak` is continuous across the whole PLAY phase. There is no gap logic.

## Test plan
Bench parameters: CLK_HZ=1_000_000, BEAT_HZ=1000 (BEAT_CYC=1000), SONG_LEN=4, ROM = {15, 0, 8, 15}.

1. Release reset, pulse `play` → `busy`=1, `note_addr`=0; `led`=1 and `high`=1 after 2 cycles; first `speak` rise 478 cycles later; toggles every 478 cycles.
2. One-shot, `loop`=0 → `note_addr` goes 0,1,2,3 at 1000-cycle intervals; `speak`=0 throughout note 1 (rest); `done` pulses once at cycle 4000; `busy`=0 afterwards.
3. `loop`=1 → after address 3, `note_addr`=0 again at cycle 4000; no `done` pulse.
4. Hold `pause` for 300 cycles in note 0 → `speak`=0 and counters frozen; the next `note_addr` change is delayed by exactly 300 cycles.
5. `stop` and `play` asserted in the same cycle mid-song → IDLE next cycle: `speak`=0, `note_addr`=0, `led`=0; `rst_n`=0 mid-note → same result.
6. With `MUSIC_ARTIC_EN` → `speak`=0 for the last 125 cycles of each beat; without it → toggling continues up to FETCH_A.
